// File: rtl/nexusv_lsu_pkg.sv
// Shared definitions for the nexusV load/store unit: RV32 funct3 encodings,
// mcause fault codes and the LSU control-state encoding.
package nexusv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic [3:0] fault_cause(input logic write, input logic misaligned);
        if (write) return misaligned ? CAUSE_STORE_MISALIGNED : CAUSE_STORE_ACCESS;
        return misaligned ? CAUSE_LOAD_MISALIGNED : CAUSE_LOAD_ACCESS;
    endfunction

endpackage

// File: rtl/nexusv_lsu_align.sv
// Combinational byte-lane logic: store data replication/strobes and load
// byte/halfword extraction with sign or zero extension.
module nexusv_lsu_align
    import nexusv_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] lane_data,
    output logic [3:0]  lane_strb,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = load_word >> {offset, 3'b000};

    always_comb begin
        lane_data = store_data;
        lane_strb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                lane_data = {4{store_data[7:0]}};
                lane_strb = 4'b0001 << offset;
            end
            2'b01: begin
                lane_data = {2{store_data[15:0]}};
                lane_strb = 4'b0011 << offset;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = load_word;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/nexusv_lsu.sv
// nexusV load/store unit: table-driven region decode, fault detection and a
// single-outstanding slave handshake. Define NEXUSV_LSU_TIMEOUT_EN for a bus timeout.
module nexusv_lsu
    import nexusv_lsu_pkg::*;
#(
    parameter int                  N_SLV       = 2,
    parameter logic [N_SLV*32-1:0] SLV_BASE    = {32'h8000_0000, 32'h0000_2000},
    parameter logic [N_SLV*32-1:0] SLV_MASK    = {32'h8000_0000, 32'hFFFF_F000},
    parameter int                  TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [2:0]          req_funct3,
    output logic                req_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic [3:0]          rsp_cause,
    output logic                slv_valid,
    output logic [N_SLV-1:0]    slv_sel,
    output logic                slv_write,
    output logic [31:0]         slv_addr,
    output logic [31:0]         slv_wdata,
    output logic [3:0]          slv_wstrb,
    input  logic [N_SLV*32-1:0] slv_rdata,
    input  logic [N_SLV-1:0]    slv_ready,
    input  logic [N_SLV-1:0]    slv_err
);

    lsu_state_t        state_reg, state_next;
    logic              req_ready_reg, req_ready_next;
    logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [3:0]        rsp_cause_reg, rsp_cause_next;
    logic              slv_valid_reg, slv_valid_next;
    logic [N_SLV-1:0]  slv_sel_reg, slv_sel_next;
    logic              slv_write_reg, slv_write_next;
    logic [31:0]       slv_addr_reg, slv_addr_next;
    logic [31:0]       slv_wdata_reg, slv_wdata_next;
    logic [3:0]        slv_wstrb_reg, slv_wstrb_next;
    logic [2:0]        funct3_reg, funct3_next;

`ifdef NEXUSV_LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
`endif

    logic [N_SLV-1:0]  hit, hit_first;
    logic [31:0]       rd_masked [N_SLV];
    logic [31:0]       sel_rdata;
    logic              sel_ready, sel_err;
    logic              misaligned, legal, mapped;
    logic [2:0]        align_funct3;
    logic [1:0]        align_offset;
    logic [31:0]       lane_data, load_data;
    logic [3:0]        lane_strb;

    // Region table: each slice is compared independently; lowest index wins.
    generate
        for (genvar gi = 0; gi < N_SLV; gi++) begin : g_region
            assign hit[gi] = (req_addr & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32];
            assign rd_masked[gi] = slv_rdata[gi*32 +: 32] & {32{slv_sel_reg[gi]}};
        end
    endgenerate

    assign hit_first = hit & (-hit);
    assign mapped    = |hit;
    assign sel_ready = |(slv_ready & slv_sel_reg);
    assign sel_err   = |(slv_err & slv_ready & slv_sel_reg);

    always_comb begin
        sel_rdata = 32'h0;
        for (int i = 0; i < N_SLV; i++) sel_rdata = sel_rdata | rd_masked[i];
    end

    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign legal = req_write ? (req_funct3 inside {F3_B, F3_H, F3_W})
                             : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    // One aligner serves both phases: request operands in IDLE, latched ones after.
    assign align_funct3 = (state_reg == ST_IDLE) ? req_funct3    : funct3_reg;
    assign align_offset = (state_reg == ST_IDLE) ? req_addr[1:0] : slv_addr_reg[1:0];

    nexusv_lsu_align u_align (
        .funct3     (align_funct3),
        .offset     (align_offset),
        .store_data (req_wdata),
        .load_word  (sel_rdata),
        .lane_data  (lane_data),
        .lane_strb  (lane_strb),
        .load_data  (load_data)
    );

    always_comb begin
        state_next     = state_reg;
        req_ready_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_cause_next = rsp_cause_reg;
        slv_valid_next = slv_valid_reg;
        slv_sel_next   = slv_sel_reg;
        slv_write_next = slv_write_reg;
        slv_addr_next  = slv_addr_reg;
        slv_wdata_next = slv_wdata_reg;
        slv_wstrb_next = slv_wstrb_reg;
        funct3_next    = funct3_reg;
`ifdef NEXUSV_LSU_TIMEOUT_EN
        tmo_cnt_next   = tmo_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    slv_addr_next  = req_addr;
                    slv_write_next = req_write;
                    funct3_next    = req_funct3;
                    rsp_rdata_next = 32'h0;
                    if (misaligned || !legal || !mapped) begin
                        state_next     = ST_RESP;
                        req_ready_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_cause_next = fault_cause(req_write, misaligned);
                    end else begin
                        state_next     = ST_ACCESS;
                        slv_valid_next = 1'b1;
                        slv_sel_next   = hit_first;
                        slv_wdata_next = req_write ? lane_data : 32'h0;
                        slv_wstrb_next = req_write ? lane_strb : 4'b0000;
                        rsp_err_next   = 1'b0;
                        rsp_cause_next = 4'd0;
`ifdef NEXUSV_LSU_TIMEOUT_EN
                        tmo_cnt_next   = '0;
`endif
                    end
                end
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_next     = ST_RESP;
                    req_ready_next = 1'b1;
                    slv_valid_next = 1'b0;
                    rsp_err_next   = sel_err;
                    rsp_cause_next = sel_err ? fault_cause(slv_write_reg, 1'b0) : 4'd0;
                    rsp_rdata_next = (slv_write_reg || sel_err) ? 32'h0 : load_data;
                end
`ifdef NEXUSV_LSU_TIMEOUT_EN
                else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_next     = ST_RESP;
                    req_ready_next = 1'b1;
                    slv_valid_next = 1'b0;
                    rsp_err_next   = 1'b1;
                    rsp_cause_next = fault_cause(slv_write_reg, 1'b0);
                    rsp_rdata_next = 32'h0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
`endif
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
            rsp_cause_reg <= 4'd0;
            slv_valid_reg <= 1'b0;
            slv_sel_reg   <= '0;
            slv_write_reg <= 1'b0;
            slv_addr_reg  <= 32'h0;
            slv_wdata_reg <= 32'h0;
            slv_wstrb_reg <= 4'b0000;
            funct3_reg    <= 3'b000;
`ifdef NEXUSV_LSU_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= req_ready_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_cause_reg <= rsp_cause_next;
            slv_valid_reg <= slv_valid_next;
            slv_sel_reg   <= slv_sel_next;
            slv_write_reg <= slv_write_next;
            slv_addr_reg  <= slv_addr_next;
            slv_wdata_reg <= slv_wdata_next;
            slv_wstrb_reg <= slv_wstrb_next;
            funct3_reg    <= funct3_next;
`ifdef NEXUSV_LSU_TIMEOUT_EN
            tmo_cnt_reg   <= tmo_cnt_next;
`endif
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_cause = rsp_cause_reg;
    assign slv_valid = slv_valid_reg;
    assign slv_sel   = slv_sel_reg;
    assign slv_write = slv_write_reg;
    assign slv_addr  = slv_addr_reg;
    assign slv_wdata = slv_wdata_reg;
    assign slv_wstrb = slv_wstrb_reg;

endmodule

// File: tb/tb_nexusv_lsu.sv
// Self-checking bench for nexusv_lsu: directed cases plus randomized traffic
// checked every cycle against a behavioural model of the LSU.
module tb_nexusv_lsu;

    localparam int NS  = 2;
    localparam int TMO = 16;
    // Slave 0 covers the upper half of the map, slave 1 the 4 KiB page at 0x2000.
    localparam logic [NS*32-1:0] P_BASE = {32'h0000_2000, 32'h8000_0000};
    localparam logic [NS*32-1:0] P_MASK = {32'hFFFF_F000, 32'h8000_0000};

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid, req_write;
    logic [31:0]    req_addr, req_wdata;
    logic [2:0]     req_funct3;
    logic           req_ready;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;
    logic [3:0]     rsp_cause;
    logic           slv_valid;
    logic [NS-1:0]  slv_sel;
    logic           slv_write;
    logic [31:0]    slv_addr, slv_wdata;
    logic [3:0]     slv_wstrb;
    logic [NS*32-1:0] slv_rdata;
    logic [NS-1:0]  slv_ready, slv_err;

    always #5 clk = ~clk;

    nexusv_lsu #(
        .N_SLV(NS), .SLV_BASE(P_BASE), .SLV_MASK(P_MASK), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .req_ready(req_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_cause(rsp_cause),
        .slv_valid(slv_valid), .slv_sel(slv_sel), .slv_write(slv_write), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
        .slv_rdata(slv_rdata), .slv_ready(slv_ready), .slv_err(slv_err)
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [2:0]  f3;
        int          waits;
        logic [31:0] srd;
        bit          serr;
        bit          never;
        int          idx;
        bit          fault;
        bit          err;
        logic [3:0]  cause;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    bit          txn_active = 0;
    bit          check_idle = 0;
    int          done_cnt = 0;
    int          n_cyc = 0;
    int          vcnt = 0;
    int          last_lat = 0;
    int          last_vcnt = 0;
    logic [31:0] last_rdata = 0;
    logic        last_err = 0;
    logic [3:0]  last_cause = 0;
    logic [NS-1:0] last_sel = 0;
    logic [3:0]  last_wstrb = 0;
    logic [31:0] last_wdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        if (a[31]) return 0;
        if (a[31:12] == 20'h00002) return 1;
        return -1;
    endfunction

    // Expected outcome of one request, derived from the LSU rules.
    function automatic exp_t model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [2:0] f3, input int waits, input logic [31:0] srd,
                                   input bit serr, input bit never);
        exp_t e;
        int sz, off;
        bit mis, legal;
        logic [31:0] v;
        e.write = w; e.addr = a; e.f3 = f3; e.waits = waits; e.srd = srd;
        e.serr = serr; e.never = never;
        e.idx = region_of(a);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && off != 0);
        legal = w ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e.wstrb = 4'b0000;
        e.wdata = 32'h0;
        e.rdata = 32'h0;
        if (w) begin
            for (int i = 0; i < 4; i++) e.wstrb[i] = (i >= off) && (i < off + sz);
            e.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        end
        if (mis || !legal || e.idx < 0) begin
            e.fault = 1; e.err = 1; e.lat = 1;
            e.cause = mis ? (w ? 4'd6 : 4'd4) : (w ? 4'd7 : 4'd5);
        end else begin
            e.fault = 0;
            e.err   = never || serr;
            e.lat   = never ? TMO + 1 : waits + 2;
            e.cause = e.err ? (w ? 4'd7 : 4'd5) : 4'd0;
            if (!w && !e.err) begin
                v = srd >> (8 * off);
                if (sz == 1) begin
                    v = v & 32'hFF;
                    if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
                end else if (sz == 2) begin
                    v = v & 32'hFFFF;
                    if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
                end
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // Slave side: the expected slave answers after cur.waits cycles; others get noise.
    initial begin
        int wcnt;
        logic [NS-1:0] noise;
        wcnt = 0;
        slv_ready = '0; slv_err = '0; slv_rdata = '0;
        forever begin
            @(negedge clk);
            slv_rdata = {$urandom, $urandom};
            slv_err   = NS'($urandom);
            noise     = NS'($urandom);
            if (cur.idx >= 0) noise[cur.idx] = 1'b0;
            slv_ready = noise;
            if (txn_active && slv_valid && !cur.fault && !cur.never && cur.idx >= 0) begin
                if (wcnt == cur.waits) begin
                    slv_ready[cur.idx] = 1'b1;
                    slv_err[cur.idx]   = cur.serr;
                    slv_rdata[cur.idx*32 +: 32] = cur.srd;
                end else begin
                    wcnt++;
                end
            end else if (!slv_valid) begin
                wcnt = 0;
            end
        end
    end

    // Compare process: checks every cycle of a transaction, and quiet outputs between them.
    always @(negedge clk) begin
        if (!txn_active) begin
            n_cyc = 0;
            vcnt  = 0;
            if (check_idle && rst_n) begin
                chk("idle_slv_valid", 32'(slv_valid), 32'd0);
                chk("idle_req_ready", 32'(req_ready), 32'd0);
            end
        end else if (n_cyc < cur.lat) begin
            n_cyc++;
            chk("slv_valid", 32'(slv_valid), 32'(!cur.fault && n_cyc < cur.lat));
            chk("req_ready", 32'(req_ready), 32'(n_cyc == cur.lat));
            if (slv_valid) begin
                vcnt++;
                last_sel   = slv_sel;
                last_wstrb = slv_wstrb;
                last_wdata = slv_wdata;
            end
            if (!cur.fault && n_cyc < cur.lat) begin
                chk("slv_sel", 32'(slv_sel), 32'(NS'(1) << cur.idx));
                chk("slv_write", 32'(slv_write), 32'(cur.write));
                chk("slv_addr", slv_addr, cur.addr);
                chk("slv_wstrb", 32'(slv_wstrb), 32'(cur.wstrb));
                if (cur.write) chk("slv_wdata", slv_wdata, cur.wdata);
            end
            if (n_cyc == cur.lat) begin
                chk("rsp_rdata", rsp_rdata, cur.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                if (cur.err) chk("rsp_cause", 32'(rsp_cause), 32'(cur.cause));
                last_lat   = n_cyc;
                last_vcnt  = vcnt;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                last_cause = rsp_cause;
                done_cnt++;
            end
        end
    end

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input int waits, input logic [31:0] srd, input bit serr, input bit never);
        int d0;
        bit got;
        @(negedge clk);
        #2;
        cur = model(w, a, wd, f3, waits, srd, serr, never);
        req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f3;
        req_valid = 1'b1;
        d0 = done_cnt;
        txn_active = 1'b1;
        got = 0;
        for (int c = 0; c < TMO + 64; c++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("txn_timeout", 32'd0, 32'd1);
        req_valid  = 1'b0;
        txn_active = 1'b0;
        $display("txn %s f3=%0d addr=%h wdata=%h waits=%0d lat=%0d err=%0b cause=%0d rdata=%h",
                 w ? "ST" : "LD", f3, a, wd, waits, last_lat, last_err, last_cause, last_rdata);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bit          w;
        logic [2:0]  ld_f3 [5];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'd0;
        cur = model(0, 32'h0, 32'h0, 3'd0, 0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_cause", 32'(rsp_cause), 32'd0);
        chk("rst_slv_valid", 32'(slv_valid), 32'd0);
        chk("rst_slv_sel", 32'(slv_sel), 32'd0);
        chk("rst_slv_write", 32'(slv_write), 32'd0);
        chk("rst_slv_addr", slv_addr, 32'd0);
        chk("rst_slv_wdata", slv_wdata, 32'd0);
        chk("rst_slv_wstrb", 32'(slv_wstrb), 32'd0);
        rst_n = 1'b1;
        check_idle = 1'b1;

        issue(0, 32'h0000_2004, 32'h0, 3'd2, 0, 32'hDEAD_BEEF, 0, 0);
        chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("lw_sel", 32'(last_sel), 32'b10);
        chk("lw_lat", 32'(last_lat), 32'd2);
        chk("lw_err", 32'(last_err), 32'd0);

        issue(0, 32'h0000_2003, 32'h0, 3'd0, 1, 32'h8011_2233, 0, 0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        issue(0, 32'h0000_2003, 32'h0, 3'd4, 2, 32'h8011_2233, 0, 0);
        chk("lbu_rdata", last_rdata, 32'h0000_0080);

        issue(1, 32'h8000_0002, 32'h0000_1234, 3'd1, 5, 32'h0, 0, 0);
        chk("sh_sel", 32'(last_sel), 32'b01);
        chk("sh_wstrb", 32'(last_wstrb), 32'b1100);
        chk("sh_wdata", last_wdata, 32'h1234_1234);
        chk("sh_lat", 32'(last_lat), 32'd7);

        issue(0, 32'h0000_2002, 32'h0, 3'd2, 0, 32'h0, 0, 0);
        chk("lw_mis_cause", 32'(last_cause), 32'd4);
        chk("lw_mis_lat", 32'(last_lat), 32'd1);
        chk("lw_mis_valid", 32'(last_vcnt), 32'd0);
        issue(1, 32'h0000_1000, 32'h5555_AAAA, 3'd2, 0, 32'h0, 0, 0);
        chk("sw_unmap_cause", 32'(last_cause), 32'd7);
        chk("sw_unmap_lat", 32'(last_lat), 32'd1);
        chk("sw_unmap_valid", 32'(last_vcnt), 32'd0);

        issue(0, 32'h0000_2000, 32'h0, 3'd2, 1, 32'h1234_5678, 1, 0);
        chk("slverr_cause", 32'(last_cause), 32'd5);
        chk("slverr_rdata", last_rdata, 32'd0);

`ifdef NEXUSV_LSU_TIMEOUT_EN
        issue(0, 32'h0000_2000, 32'h0, 3'd2, 0, 32'h0, 0, 1);
        chk("tmo_valid_cycles", 32'(last_vcnt), 32'd16);
        chk("tmo_cause", 32'(last_cause), 32'd5);
`endif

        // Reset in the middle of an access: slave request must drop at once.
        @(negedge clk);
        check_idle = 1'b0;
        cur = model(0, 32'h0000_2008, 32'h0, 3'd2, 0, 32'h0, 0, 1);
        req_write = 1'b0; req_addr = 32'h0000_2008; req_funct3 = 3'd2; req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mid_valid_before", 32'(slv_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid_async", 32'(slv_valid), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        check_idle = 1'b1;
        issue(0, 32'h0000_2008, 32'h0, 3'd2, 0, 32'hCAFE_F00D, 0, 0);
        chk("post_rst_rdata", last_rdata, 32'hCAFE_F00D);

        for (int t = 0; t < 200; t++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0, 1:    a = {1'b1, 31'($urandom)};
                2, 3:    a = {20'h00002, 12'($urandom)};
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom);
                a[1:0] = 2'b00;
            end else begin
                f3 = w ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            end
            issue(w, a, $urandom, f3, int'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 9) == 0, 0);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
